ram_row_streamer: RTL and testbench
===================================

// Module: ram_row_streamer
// PURPOSE
//  Reads the processed image rows that the edge detector leaves in the result RAM
//  and streams them out as bytes over a valid/ready handshake toward a UART/host link.
//  It is the RAM reader that sits opposite the edge detector's RAM write port.
//  Start-triggered; one full image of NUM_ROWS rows per run.
// PARAMETERS
//  DATA_W    64  RAM word width (bits per image row); must be a multiple of 8
//  ADDR_W    7   RAM address width
//  NUM_ROWS  48  rows per image; valid addresses are 0..NUM_ROWS-1
// PORTS
//  clk               in   1       clock, all logic on posedge
//  rst               in   1       synchronous, active-high reset
//  start             in   1       begin streaming one image; sampled only in IDLE
//  ram_rdata         in   DATA_W  RAM read data; valid 1 cycle after ram_read_request
//  ram_raddr         out  ADDR_W  RAM read address (current row)
//  ram_read_request  out  1       RAM read strobe, 1-cycle pulse per row
//  tx_data           out  8       byte to transmit
//  tx_valid          out  1       tx_data is valid
//  tx_ready          in   1       sink accepts tx_data this cycle
//  busy              out  1       high in every state except IDLE
//  done              out  1       1-cycle pulse after the last byte of the image is accepted
// BEHAVIOUR
//  - Reset: state=IDLE, row=0, byte_cnt=0, shift reg=0; every output is 0.
//  - FSM: IDLE -> REQ -> CAPT -> SEND -> (REQ | FIN) -> IDLE.
//    IDLE: wait for start=1; load row=0.
//    REQ:  ram_raddr=row, ram_read_request=1 for exactly this one cycle.
//    CAPT: capture ram_rdata into the DATA_W shift register; byte_cnt=0.
//    SEND: tx_valid=1, tx_data=shift[7:0] (LSB byte first). On tx_valid&&tx_ready:
//          shift right by 8 and byte_cnt++. On the handshake of byte DATA_W/8-1:
//          if row==NUM_ROWS-1 -> FIN, else row++ and go to REQ.
//    FIN:  done=1 for one cycle -> IDLE.
//  - Timing: start sampled at edge k -> REQ at k+1, CAPT at k+2, tx_valid=1 from k+3.
//    Between rows, tx_valid is low for 2 cycles (REQ, CAPT).
//  - Handshake: while tx_valid=1 and tx_ready=0, tx_data must stay stable.
//    tx_valid must not drop until that byte is accepted.
//    tx_ready is ignored while tx_valid=0.
//  - start asserted while busy=1 is ignored and is not queued.
//  - ram_raddr holds its last value outside REQ; it is never NUM_ROWS or greater.
//  - Reset mid-operation: returns to IDLE next cycle, any byte not yet accepted is dropped.
//  - Width rules: row counter is ADDR_W bits wide, byte_cnt is clog2(DATA_W/8) bits; neither wraps inside a run.
// CONFIGURATION
//  ROW_HEADER_EN defined:
//   - each row is preceded by one header byte {1'b1, row[6:0]}, sent from SEND state before the row data
//   - the header goes through the same valid/ready handshake as data bytes
//   - bytes per image = NUM_ROWS*(DATA_W/8+1) = 432 at the defaults
//  ROW_HEADER_EN undefined:
//   - no header; bytes per image = NUM_ROWS*DATA_W/8 = 384 at the defaults
// TESTING
//  1 Reset: hold rst 2 cycles -> all outputs 0, busy=0; start held 0 -> no ram_read_request.
//  2 RAM row0=64'h0807060504030201, tx_ready=1, pulse start -> ram_read_request at start+1 with ram_raddr=0;
//    tx_data 01,02,..,08 on consecutive cycles from start+3.
//  3 Full image, RAM[n]={8{n[7:0]}}, tx_ready=1 -> 384 bytes, addresses 0..47 each read once,
//    done pulses once, then busy=0.
//  4 Backpressure: tx_ready low 5 cycles during byte 3 of row 0 -> tx_data=04 held stable and
//    tx_valid held; no extra RAM read.
//  5 Pulse start mid-row 10 -> ignored, byte count unchanged; assert rst mid-row 20 -> IDLE next cycle;
//    a new start restarts at row 0.
//  6 ROW_HEADER_EN, row5=64'h0 -> tx_data 85 then eight 00; 432 bytes total.

Source files
------------

// File: rtl/ram_row_streamer.sv
// ram_row_streamer: reads image rows from the result RAM and streams them
// out LSB byte first over a valid/ready byte link. Optional ROW_HEADER_EN
// macro prefixes every row with a header byte {1'b1, row[6:0]}.
module ram_row_streamer #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 7,
    parameter int NUM_ROWS = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_read_request,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int NB  = DATA_W / 8;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [BCW-1:0]    LAST_B   = BCW'(NB - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

`ifdef ROW_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_SEND,
        S_FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] row;
    logic [BCW-1:0]    byte_cnt;
    logic [DATA_W-1:0] shift;
    logic              hdr;

    logic [DATA_W-1:0] shift_nxt;
    logic [6:0]        row7;
    logic [7:0]        hdr_byte;

    assign shift_nxt = shift >> 8;
    assign row7      = 7'(row);
    assign hdr_byte  = {1'b1, row7};
    assign busy      = (state != S_IDLE);

    // Row sequencer: request, capture, then drain one byte per handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            row              <= '0;
            byte_cnt         <= '0;
            shift            <= '0;
            hdr              <= 1'b0;
            ram_raddr        <= '0;
            ram_read_request <= 1'b0;
            tx_data          <= '0;
            tx_valid         <= 1'b0;
            done             <= 1'b0;
        end else begin
            ram_read_request <= 1'b0;
            done             <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        row              <= '0;
                        ram_raddr        <= '0;
                        ram_read_request <= 1'b1;
                        state            <= S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_CAPT;
                end
                S_CAPT: begin
                    shift    <= ram_rdata;
                    byte_cnt <= '0;
                    hdr      <= HDR_EN;
                    tx_valid <= 1'b1;
                    tx_data  <= HDR_EN ? hdr_byte : ram_rdata[7:0];
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (hdr) begin
                            hdr     <= 1'b0;
                            tx_data <= shift[7:0];
                        end else if (byte_cnt == LAST_B) begin
                            // Last byte of the row: counter stays put, no wrap.
                            tx_valid <= 1'b0;
                            if (row == LAST_ROW) begin
                                done  <= 1'b1;
                                state <= S_FIN;
                            end else begin
                                row              <= row + 1'b1;
                                ram_raddr        <= row + 1'b1;
                                ram_read_request <= 1'b1;
                                state            <= S_REQ;
                            end
                        end else begin
                            shift    <= shift_nxt;
                            tx_data  <= shift_nxt[7:0];
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_row_streamer.sv
// tb_ram_row_streamer: scoreboard bench for ram_row_streamer with a
// registered-read RAM model; define ROW_HEADER_EN for both to test headers.
module tb_ram_row_streamer;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 7;
    localparam int NUM_ROWS = 48;
    localparam int NB       = DATA_W / 8;
`ifdef ROW_HEADER_EN
    localparam int BPR = NB + 1;
    localparam bit HDR = 1'b1;
`else
    localparam int BPR = NB;
    localparam bit HDR = 1'b0;
`endif
    localparam int TOTAL = NUM_ROWS * BPR;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              tx_ready = 1'b0;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [ADDR_W-1:0] ram_raddr;
    logic              ram_read_request;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              busy;
    logic              done;

    ram_row_streamer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_ROWS(NUM_ROWS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ram_rdata(ram_rdata),
        .ram_raddr(ram_raddr),
        .ram_read_request(ram_read_request),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:NUM_ROWS-1];

    always @(posedge clk)
        if (ram_read_request && ram_raddr < NUM_ROWS)
            ram_rdata <= mem[ram_raddr];

    int vecs = 0;
    int errs = 0;
    logic [7:0] q[$];
    int acc = 0;
    int reads = 0;
    int dones = 0;
    int exp_addr = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake, checks reads/holds.
    logic       pv = 1'b0;
    logic [7:0] pd = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (pv) begin
                check("hold_valid", 64'(tx_valid), 64'd1);
                check("hold_data", 64'(tx_data), 64'(pd));
            end
            if (tx_valid && tx_ready) begin
                if (q.size() == 0) begin
                    check("extra_byte", 64'd1, 64'd0);
                end else begin
                    check("byte", 64'(tx_data), 64'(q.pop_front()));
                end
                acc++;
            end
            if (ram_read_request) begin
                check("raddr", 64'(ram_raddr), 64'(exp_addr));
                check("raddr_range", 64'(ram_raddr < NUM_ROWS), 64'd1);
                exp_addr++;
                reads++;
            end
            if (done) dones++;
            pv = tx_valid && !tx_ready;
            pd = tx_data;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_and_load();
        q.delete();
        acc = 0;
        reads = 0;
        dones = 0;
        exp_addr = 0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (HDR) q.push_back(8'h80 | 8'(r));
            for (int b = 0; b < NB; b++) q.push_back(mem[r][8*b +: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_acc(input int n);
        int i;
        i = 0;
        while (acc < n && i < 3000) begin
            step();
            i++;
        end
        check("acc_reach", 64'(acc), 64'(n));
    endtask

    task automatic finish_image();
        int i;
        i = 0;
        while (dones < 1 && i < 3000) begin
            step();
            i++;
        end
        repeat (4) step();
        check("done_once", 64'(dones), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("bytes_total", 64'(acc), 64'(TOTAL));
        check("reads_total", 64'(reads), 64'(NUM_ROWS));
        check("sb_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        for (int n = 0; n < NUM_ROWS; n++) mem[n] = {8{8'(n)}};
        mem[0] = 64'h0807060504030201;
        mem[5] = 64'h0;

        // Reset and idle with start low
        step();
        step();
        check("rst_valid", 64'(tx_valid), 64'd0);
        check("rst_data", 64'(tx_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_req", 64'(ram_read_request), 64'd0);
        check("rst_raddr", 64'(ram_raddr), 64'd0);
        rst = 1'b0;
        repeat (4) step();
        check("idle_no_read", 64'(reads), 64'd0);

        // Row 0 latency then full image at full rate
        clear_and_load();
        tx_ready = 1'b1;
        pulse_start();
        check("req_cycle", 64'(ram_read_request), 64'd1);
        check("req_addr0", 64'(ram_raddr), 64'd0);
        check("busy_run", 64'(busy), 64'd1);
        step();
        check("capt_req", 64'(ram_read_request), 64'd0);
        check("capt_valid", 64'(tx_valid), 64'd0);
        step();
        check("first_valid", 64'(tx_valid), 64'd1);
        check("first_byte", 64'(tx_data), HDR ? 64'h80 : 64'h01);
        finish_image();

        // Backpressure on byte 3 of row 0
        clear_and_load();
        pulse_start();
        wait_acc(BPR - NB + 3);
        tx_ready = 1'b0;
        repeat (5) begin
            check("bp_valid", 64'(tx_valid), 64'd1);
            check("bp_data", 64'(tx_data), 64'h04);
            check("bp_reads", 64'(reads), 64'd1);
            step();
        end
        tx_ready = 1'b1;

        // start pulsed mid-row 10 is ignored
        wait_acc(10 * BPR + 2);
        pulse_start();
        finish_image();
        repeat (5) step();
        check("no_queued_start", 64'(reads), 64'(NUM_ROWS));
        check("idle_busy", 64'(busy), 64'd0);

        // Reset mid-row 20, then restart from row 0
        clear_and_load();
        pulse_start();
        wait_acc(20 * BPR + 3);
        rst = 1'b1;
        step();
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_valid", 64'(tx_valid), 64'd0);
        check("mrst_req", 64'(ram_read_request), 64'd0);
        rst = 1'b0;
        clear_and_load();
        step();
        pulse_start();
        check("restart_req", 64'(ram_read_request), 64'd1);
        check("restart_addr", 64'(ram_raddr), 64'd0);
        finish_image();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
